tx_redundant: RTL

- Transmit-side counterpart of the redundant-frame receiver.
- Buffers one outgoing frame body, then sends it 1, 3 or 5 times back-to-back on a GMII-style byte interface. Each copy is preceded by preamble/SFD.
- In every copy, the copy index is inserted at byte offset ID_LOC and an 8-bit frame sequence number at ID_LOC+1, so the receiver can vote across copies and detect lost frames.
- Sits between the frame source and the PHY TX pins, in the 125 MHz domain.

---
 rtl/tx_redundant_pkg.sv | 31 +++
 rtl/tx_redundant_crc32_d8.sv | 44 ++++
 rtl/tx_redundant.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_redundant_pkg.sv
// tx_redundant_pkg: shared types and constants for the redundant-frame transmitter.
//   state_e       : transmit FSM states
//   PRE_BYTE      : preamble byte, SFD_BYTE: start-of-frame delimiter
//   CRC_POLY      : reflected IEEE 802.3 CRC-32 polynomial
//   copies_for()  : 2-bit redundancy code -> number of copies (0 means disabled)
package tx_redundant_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StGap,
        StSend,
        StDone
    } state_e;

    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    function automatic logic [2:0] copies_for(input logic [1:0] code);
        logic [2:0] n;
        case (code)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd3;
            2'd2:    n = 3'd5;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tx_redundant_crc32_d8.sv
// crc32_d8: byte-wide Ethernet CRC-32 accumulator (reflected, LSB first).
//   clk, rst : clock, asynchronous active-low reset
//   init     : load the all-ones seed (has priority over en)
//   en       : fold data into the running remainder
//   data     : input byte
//   crc      : final FCS value (complemented remainder), send crc[7:0] first
module crc32_d8
    import tx_redundant_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < 8; i++) begin
            if (crc_d[0] ^ data[i]) begin
                crc_d = (crc_d >> 1) ^ CRC_POLY;
            end else begin
                crc_d = crc_d >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= 32'hFFFF_FFFF;
        end else if (init) begin
            crc_q <= 32'hFFFF_FFFF;
        end else if (en) begin
            crc_q <= crc_d;
        end
    end

    assign crc = ~crc_q;

endmodule

// File: rtl/tx_redundant.sv
// tx_redundant: buffers one frame body and transmits it 1, 3 or 5 times on a
// GMII-style byte interface. Every copy gets preamble/SFD, the copy index at
// offset ID_LOC and the frame sequence number at ID_LOC+1 (offsets counted from
// the first preamble byte). Short bodies are zero-padded so those offsets exist.
// Optional feature: define TX_FCS_EN to append a per-copy CRC-32 FCS.
//   clk       : 125 MHz clock
//   rst       : asynchronous active-low reset
//   switches  : [5:4] redundancy code (0:1 copy, 1:3, 2:5, 3:disabled)
//   in_en     : body byte valid (contiguous for one frame)
//   in_data   : body byte
//   in_ready  : a new frame may start
//   tx_en     : registered TX valid
//   tx_data   : registered TX byte (0 while tx_en is low)
//   busy      : frame in progress
//   overflow  : pulse per byte dropped on a full buffer
//   seq       : sequence number of the last fully sent frame
module tx_redundant
    import tx_redundant_pkg::*;
#(
    parameter int unsigned ID_LOC  = 6'h22,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned IFG     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] switches,
    input  logic       in_en,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] seq
);

    localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [15:0] MaxLen  = 16'(MAX_LEN);
    localparam logic [15:0] IdLoc   = 16'(ID_LOC);
    localparam logic [15:0] MinBody = 16'(ID_LOC - 6);
    localparam logic [15:0] IfgLast = 16'(IFG - 1);
`ifdef TX_FCS_EN
    localparam logic [15:0] FcsLen  = 16'd4;
`else
    localparam logic [15:0] FcsLen  = 16'd0;
`endif

    state_e      state_q, state_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] len_q, len_d;
    logic [15:0] pos_q, pos_d;
    logic [15:0] gap_q, gap_d;
    logic [1:0]  red_q, red_d;
    logic [2:0]  copy_q, copy_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  seq_q, seq_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        ovf_q, ovf_d;

    logic [15:0] body_len;
    logic [15:0] last_pos;
    logic [15:0] nxt_off;
    logic [15:0] body_idx;
    logic [15:0] rd_idx;
    logic [2:0]  n_copies;
    logic [2:0]  copy_inc;
    logic [7:0]  send_byte;

    logic        unused_sw;
    assign unused_sw = ^switches[3:0];

    // Body buffer: single port, registered read. Writes happen only while
    // loading and reads only while sending, so one address mux suffices.
    logic [7:0]    mem [MAX_LEN];
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= in_data;
        end
        ram_q <= mem[ram_addr];
    end

    assign body_len = (len_q > MinBody) ? len_q : MinBody;
    assign last_pos = body_len + 16'd7 + FcsLen;
    // pos_q is the offset now on tx_data; the byte being built is the next one.
    assign nxt_off  = pos_q + 16'd1;
    assign body_idx = nxt_off - 16'd8;
    // Read two offsets ahead so ram_q lines up with body_idx one cycle later.
    assign rd_idx   = pos_q - 16'd6;
    assign n_copies = copies_for(red_q);
    assign copy_inc = copy_q + 3'd1;

`ifdef TX_FCS_EN
    logic        crc_init;
    logic        crc_en;
    logic [31:0] fcs;
    logic [15:0] fcs_sel;

    assign crc_init = (state_q == StGap) && (gap_q == IfgLast);
    assign crc_en   = (state_q == StSend) && (nxt_off >= 16'd8) && (body_idx < body_len);
    assign fcs_sel  = body_idx - body_len;

    crc32_d8 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .data (send_byte),
        .crc  (fcs)
    );
`endif

    // Byte for copy offset nxt_off.
    always_comb begin
        send_byte = 8'h00;
        if (nxt_off < 16'd7) begin
            send_byte = PRE_BYTE;
        end else if (nxt_off == 16'd7) begin
            send_byte = SFD_BYTE;
        end else if (body_idx < body_len) begin
            if (nxt_off == IdLoc) begin
                send_byte = {5'b0, copy_q};
            end else if (nxt_off == IdLoc + 16'd1) begin
                send_byte = cnt_q;
            end else if (body_idx < len_q) begin
                send_byte = ram_q;
            end
        end else begin
`ifdef TX_FCS_EN
            case (fcs_sel[1:0])
                2'd0:    send_byte = fcs[7:0];
                2'd1:    send_byte = fcs[15:8];
                2'd2:    send_byte = fcs[23:16];
                default: send_byte = fcs[31:24];
            endcase
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        len_d     = len_q;
        pos_d     = pos_q;
        gap_d     = gap_q;
        red_d     = red_q;
        copy_d    = copy_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        tx_en_d   = 1'b0;
        tx_data_d = 8'h00;
        ovf_d     = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;

        case (state_q)
            StIdle: begin
                if (in_en) begin
                    ram_we    = 1'b1;
                    wr_addr_d = 16'd1;
                    red_d     = switches[5:4];
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                if (in_en) begin
                    if (wr_addr_q < MaxLen) begin
                        ram_we    = 1'b1;
                        ram_addr  = wr_addr_q[AW-1:0];
                        wr_addr_d = wr_addr_q + 16'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    len_d = wr_addr_q;
                    if (n_copies == 3'd0) begin
                        state_d = StIdle;
                    end else begin
                        copy_d  = 3'd0;
                        gap_d   = 16'd0;
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                // Load the first preamble byte so it shows right after the gap.
                if (gap_q == IfgLast) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = PRE_BYTE;
                    pos_d     = 16'd0;
                    state_d   = StSend;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            StSend: begin
                if ((pos_q >= 16'd6) && (rd_idx < MaxLen)) begin
                    ram_addr = rd_idx[AW-1:0];
                end
                if (pos_q == last_pos) begin
                    copy_d  = copy_inc;
                    gap_d   = 16'd0;
                    state_d = (copy_inc < n_copies) ? StGap : StDone;
                end else begin
                    tx_en_d   = 1'b1;
                    tx_data_d = send_byte;
                    pos_d     = nxt_off;
                end
            end
            StDone: begin
                seq_d   = cnt_q;
                cnt_d   = cnt_q + 8'd1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            wr_addr_q <= 16'd0;
            len_q     <= 16'd0;
            pos_q     <= 16'd0;
            gap_q     <= 16'd0;
            red_q     <= 2'd0;
            copy_q    <= 3'd0;
            cnt_q     <= 8'd0;
            seq_q     <= 8'd0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            len_q     <= len_d;
            pos_q     <= pos_d;
            gap_q     <= gap_d;
            red_q     <= red_d;
            copy_q    <= copy_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign overflow = ovf_q;
    assign seq      = seq_q;

endmodule
